// File: rtl/uart_tx_fifo_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_drain_if
//  Description : Read-side handshake between the usb2serial TX FIFO and the
//                UART drain engine.
//                  Fifo_Pop_Flag  FIFO -> drain   4'h0 means empty
//                  Fifo_Dout      FIFO -> drain   head / popped byte
//                  Fifo_Pop       drain -> FIFO   one-cycle pop strobe
//                Modport master = drain engine, slave = FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_drain_if;
    logic [3:0] Fifo_Pop_Flag;
    logic [7:0] Fifo_Dout;
    logic       Fifo_Pop;

    modport master (
        input  Fifo_Pop_Flag,
        input  Fifo_Dout,
        output Fifo_Pop
    );

    modport slave (
        output Fifo_Pop_Flag,
        output Fifo_Dout,
        input  Fifo_Pop
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_drain
//  Description : Pops bytes from the TX FIFO one at a time and serialises
//                them onto the UART TX pin (8 data bits, optional parity,
//                1 or 2 stop bits). CTS_n and Tx_En gate frame starts only.
//  Ports       : Clk, Rst_n (async, active-low)
//                Tx_En, Baud_Div, Parity_En, Parity_Odd, Two_Stop, Cts_n
//                fifo (master modport: Fifo_Pop_Flag, Fifo_Dout, Fifo_Pop)
//                Tx, Busy, Tx_Done (all registered)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo_drain #(
    parameter int RD_LATENCY = 0,
    parameter int DIV_W      = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Tx_En,
    input  logic [DIV_W-1:0]     Baud_Div,
    input  logic                 Parity_En,
    input  logic                 Parity_Odd,
    input  logic                 Two_Stop,
    input  logic                 Cts_n,
    uart_tx_fifo_drain_if.master fifo,
    output logic                 Tx,
    output logic                 Busy,
    output logic                 Tx_Done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_POP    = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_START  = 3'd3;
    localparam logic [2:0] c_DATA   = 3'd4;
    localparam logic [2:0] c_PARITY = 3'd5;
    localparam logic [2:0] c_STOP   = 3'd6;

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_TWO = DIV_W'(2);

    // Index of the WAIT cycle in which the popped byte is valid.
    localparam int         c_WAIT_LAST_I = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;
    localparam logic [1:0] c_WAIT_LAST   = c_WAIT_LAST_I[1:0];

    logic [2:0]       state_q,  state_d;
    logic [DIV_W-1:0] baud_q,   baud_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [2:0]       bit_q,    bit_d;
    logic [1:0]       wait_q,   wait_d;
    logic             stop2_q,  stop2_d;
    logic [7:0]       shift_q,  shift_d;
    logic             pe_q,     pe_d;
    logic             par_q,    par_d;
    logic             two_q,    two_d;
    logic             tx_q,     tx_d;
    logic             pop_q,    pop_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             cts_s1_q, cts_s2_q;

    logic             w_start;
    logic             w_tick;
    logic [DIV_W-1:0] w_div_eff;
    logic [2:0]       w_bit_nxt;

    // Divisors below 2 would give a degenerate bit time.
    assign w_div_eff = (Baud_Div < c_TWO) ? c_TWO : Baud_Div;
    assign w_tick    = (baud_q == '0);
    assign w_bit_nxt = bit_q + 3'd1;

    // CTS_n synchroniser; resets to "not clear" so nothing starts until
    // the real level has propagated through both stages.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cts_s1_q <= 1'b1;
            cts_s2_q <= 1'b1;
        end else begin
            cts_s1_q <= Cts_n;
            cts_s2_q <= cts_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        div_d   = div_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        stop2_d = stop2_q;
        shift_d = shift_q;
        pe_d    = pe_q;
        par_d   = par_q;
        two_d   = two_q;
        tx_d    = tx_q;
        pop_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        w_start = 1'b0;

        case (state_q)
            c_IDLE: begin
                tx_d = 1'b1;
                if (Tx_En && !cts_s2_q && (fifo.Fifo_Pop_Flag != 4'h0)) begin
                    state_d = c_POP;
                    pop_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            c_POP: begin
                if (RD_LATENCY == 0) begin
                    w_start = 1'b1;
                end else begin
                    state_d = c_WAIT;
                    wait_d  = 2'd0;
                end
            end
            c_WAIT: begin
                if (wait_q == c_WAIT_LAST) begin
                    w_start = 1'b1;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            c_START: begin
                if (w_tick) begin
                    state_d = c_DATA;
                    bit_d   = 3'd0;
                    baud_d  = div_q - c_ONE;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - c_ONE;
                end
            end
            c_DATA: begin
                if (w_tick) begin
                    baud_d = div_q - c_ONE;
                    if (bit_q == 3'd7) begin
                        if (pe_q) begin
                            state_d = c_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = c_STOP;
                            tx_d    = 1'b1;
                            stop2_d = 1'b0;
                        end
                    end else begin
                        bit_d = w_bit_nxt;
                        tx_d  = shift_q[w_bit_nxt];
                    end
                end else begin
                    baud_d = baud_q - c_ONE;
                end
            end
            c_PARITY: begin
                if (w_tick) begin
                    state_d = c_STOP;
                    baud_d  = div_q - c_ONE;
                    tx_d    = 1'b1;
                    stop2_d = 1'b0;
                end else begin
                    baud_d = baud_q - c_ONE;
                end
            end
            c_STOP: begin
                if (w_tick) begin
                    if (two_q && !stop2_q) begin
                        stop2_d = 1'b1;
                        baud_d  = div_q - c_ONE;
                    end else begin
                        state_d = c_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - c_ONE;
                end
            end
            default: begin
                state_d = c_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame start: capture the byte and freeze the frame configuration
        // so mid-frame changes on the inputs cannot disturb this frame.
        if (w_start) begin
            state_d = c_START;
            shift_d = fifo.Fifo_Dout;
            div_d   = w_div_eff;
            baud_d  = w_div_eff - c_ONE;
            pe_d    = Parity_En;
            par_d   = (^fifo.Fifo_Dout) ^ Parity_Odd;
            two_d   = Two_Stop;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= c_IDLE;
            baud_q  <= '0;
            div_q   <= '0;
            bit_q   <= 3'd0;
            wait_q  <= 2'd0;
            stop2_q <= 1'b0;
            shift_q <= 8'h00;
            pe_q    <= 1'b0;
            par_q   <= 1'b0;
            two_q   <= 1'b0;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            stop2_q <= stop2_d;
            shift_q <= shift_d;
            pe_q    <= pe_d;
            par_q   <= par_d;
            two_q   <= two_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo.Fifo_Pop = pop_q;
    assign Tx            = tx_q;
    assign Busy          = busy_q;
    assign Tx_Done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo_drain
//  Description : Self-checking bench for uart_tx_fifo_drain. A small FIFO
//                model feeds the DUT; every pushed byte is queued as an
//                expected frame and a Tx line decoder pops and compares it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        pe;
        logic        podd;
        logic        two;
        int          exp_len;
        logic        exp_par;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Tx_En;
    logic [15:0] Baud_Div;
    logic        Parity_En;
    logic        Parity_Odd;
    logic        Two_Stop;
    logic        Cts_n;
    logic        Tx;
    logic        Busy;
    logic        Tx_Done;

    uart_tx_fifo_drain_if fif ();

    uart_tx_fifo_drain #(.RD_LATENCY(0), .DIV_W(16)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Tx_En      (Tx_En),
        .Baud_Div   (Baud_Div),
        .Parity_En  (Parity_En),
        .Parity_Odd (Parity_Odd),
        .Two_Stop   (Two_Stop),
        .Cts_n      (Cts_n),
        .fifo       (fif),
        .Tx         (Tx),
        .Busy       (Busy),
        .Tx_Done    (Tx_Done)
    );

    always #5 Clk = ~Clk;

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- FIFO model (unregistered read) ----------------
    logic [7:0] mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pops   = 0;
    int         pop_empty = 0;
    int         fcnt;

    assign fcnt              = wr_ptr - rd_ptr;
    assign fif.Fifo_Dout     = mem[rd_ptr[3:0]];
    assign fif.Fifo_Pop_Flag = (fcnt == 0) ? 4'h0 : ((fcnt > 15) ? 4'hF : 4'(fcnt));

    always @(posedge Clk) begin
        if (fif.Fifo_Pop) begin
            if (wr_ptr == rd_ptr) pop_empty <= pop_empty + 1;
            else                  rd_ptr    <= rd_ptr + 1;
            pops <= pops + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    int         cur_div  = 4;
    logic       cur_pe   = 1'b0;
    logic       cur_podd = 1'b0;
    logic       cur_two  = 1'b0;
    logic       last_par = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic pe, input logic podd, input logic two);
        Baud_Div   = div;
        Parity_En  = pe;
        Parity_Odd = podd;
        Two_Stop   = two;
        cur_div    = (div < 16'd2) ? 2 : int'(div);
        cur_pe     = pe;
        cur_podd   = podd;
        cur_two    = two;
    endtask

    // ---------------- Tx line decoder ----------------
    int mon_pos;
    bit mon_abort;

    task automatic mon_wait_to(input int target);
        while (mon_pos < target && !mon_abort) begin
            @(negedge Clk);
            mon_pos++;
            if (!Rst_n) mon_abort = 1'b1;
        end
    endtask

    task automatic mon_decode();
        int         d;
        int         pe_i;
        logic [7:0] data;
        logic [7:0] e;
        logic       p;
        logic       s1;
        logic       s2;
        d    = cur_div;
        pe_i = cur_pe ? 1 : 0;
        mon_pos   = 1;
        mon_abort = 1'b0;
        p  = 1'b0;
        s2 = 1'b1;
        data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mon_wait_to(d * (1 + i) + d / 2 + 1);
            data[i] = Tx;
        end
        if (cur_pe) begin
            mon_wait_to(d * 9 + d / 2 + 1);
            p = Tx;
        end
        mon_wait_to(d * (9 + pe_i) + d / 2 + 1);
        s1 = Tx;
        if (cur_two) begin
            mon_wait_to(d * (10 + pe_i) + d / 2 + 1);
            s2 = Tx;
        end
        if (mon_abort) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(data), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("frame_data", 32'(data), 32'(e));
            if (cur_pe) chk("frame_parity", 32'(p), 32'((^e) ^ cur_podd));
            last_par = p;
            chk("stop1", 32'(s1), 32'd1);
            if (cur_two) chk("stop2", 32'(s2), 32'd1);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge Clk);
            if (Rst_n === 1'b1 && Tx === 1'b0) mon_decode();
        end
    end

    // ---------------- helpers for the main sequence ----------------
    task automatic wait_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (Tx === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("timeout_start", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (Tx_Done === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) chk("timeout_done", 32'd0, 32'd1);
    endtask

    // Frame length in clocks from first start-bit clock to end of last stop.
    task automatic measure(output int len);
        bit ok;
        int cnt;
        len = -1;
        wait_low(ok);
        if (ok) begin
            cnt = 1;
            for (int i = 0; i < 3000; i++) begin
                @(negedge Clk);
                cnt++;
                if (cnt == 2) chk("busy_in_frame", 32'(Busy), 32'd1);
                if (Tx_Done === 1'b1) begin len = cnt - 1; break; end
            end
            if (len < 0) chk("timeout_frame", 32'd0, 32'd1);
        end
    endtask

    vec_t vecs [6];

    initial begin : main
        int len;
        int p0;
        int g;
        int n;
        int txlow;
        int popcnt;
        bit ok;

        vecs[0] = '{8'h55, 16'd4, 1'b0, 1'b0, 1'b0, 40, 1'b0};
        vecs[1] = '{8'h07, 16'd3, 1'b1, 1'b0, 1'b0, 33, 1'b1};
        vecs[2] = '{8'h07, 16'd3, 1'b1, 1'b1, 1'b0, 33, 1'b0};
        vecs[3] = '{8'hC3, 16'd0, 1'b0, 1'b0, 1'b1, 22, 1'b0};
        vecs[4] = '{8'h3C, 16'd1, 1'b1, 1'b1, 1'b1, 24, 1'b1};
        vecs[5] = '{8'h80, 16'd5, 1'b1, 1'b0, 1'b1, 60, 1'b1};

        Rst_n = 1'b0;
        Tx_En = 1'b1;
        Cts_n = 1'b0;
        set_cfg(16'd4, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_tx",   32'(Tx),           32'd1);
        chk("rst_busy", 32'(Busy),         32'd0);
        chk("rst_done", 32'(Tx_Done),      32'd0);
        chk("rst_pop",  32'(fif.Fifo_Pop), 32'd0);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);

        // Table-driven single frames
        for (int v = 0; v < 6; v++) begin
            set_cfg(vecs[v].div, vecs[v].pe, vecs[v].podd, vecs[v].two);
            p0 = pops;
            push_byte(vecs[v].data);
            measure(len);
            chk($sformatf("len_v%0d", v), 32'(len), 32'(vecs[v].exp_len));
            chk($sformatf("busy_after_v%0d", v), 32'(Busy), 32'd0);
            repeat (3) @(negedge Clk);
            chk($sformatf("pops_v%0d", v), 32'(pops - p0), 32'd1);
            if (vecs[v].pe) chk($sformatf("par_v%0d", v), 32'(last_par), 32'(vecs[v].exp_par));
        end

        // Back-to-back frames: 2 idle clocks between frames
        set_cfg(16'd2, 1'b0, 1'b0, 1'b0);
        p0 = pops;
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        wait_low(ok);
        for (int f = 0; f < 3; f++) begin
            wait_done();
            if (f < 2) begin
                g = 1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge Clk);
                    if (Tx === 1'b0) break;
                    g++;
                end
                chk($sformatf("gap_%0d", f), 32'(g), 32'd2);
            end
        end
        repeat (3) @(negedge Clk);
        chk("b2b_busy_low", 32'(Busy), 32'd0);
        chk("b2b_pops", 32'(pops - p0), 32'd3);

        // CTS_n raised mid-frame holds off the second byte
        set_cfg(16'd3, 1'b0, 1'b0, 1'b0);
        p0 = pops;
        push_byte(8'h5A);
        push_byte(8'hA5);
        wait_low(ok);
        repeat (10) @(negedge Clk);
        Cts_n = 1'b1;
        wait_done();
        txlow = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (Tx !== 1'b1) txlow++;
        end
        chk("cts_hold_pops", 32'(pops - p0), 32'd1);
        chk("cts_hold_tx", 32'(txlow), 32'd0);
        Cts_n = 1'b0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            if (fif.Fifo_Pop === 1'b1) begin n = i; break; end
        end
        chk("cts_release_delay", 32'(n), 32'd3);
        wait_done();
        repeat (3) @(negedge Clk);
        chk("cts_pops", 32'(pops - p0), 32'd2);

        // Reset during data bit 3
        set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
        push_byte(8'h96);
        wait_low(ok);
        repeat (17) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("midrst_tx",   32'(Tx),           32'd1);
        chk("midrst_busy", 32'(Busy),         32'd0);
        chk("midrst_pop",  32'(fif.Fifo_Pop), 32'd0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        push_byte(8'h69);
        measure(len);
        chk("post_rst_len", 32'(len), 32'd40);
        repeat (5) @(negedge Clk);

        // Empty FIFO: no pop, Tx idle
        popcnt = 0;
        txlow  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (fif.Fifo_Pop !== 1'b0) popcnt++;
            if (Tx !== 1'b1) txlow++;
        end
        chk("empty_pops", 32'(popcnt), 32'd0);
        chk("empty_tx", 32'(txlow), 32'd0);
        chk("pop_while_empty", 32'(pop_empty), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
